// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: parametrised pipeline-stage register with a local valid/ready
// handshake. It replaces the fixed per-stage registers and the global stall vector.
//   SKID_EN=1 : 2-entry skid buffer. up_ready comes straight from a flop.
//   SKID_EN=0 : single entry. up_ready = !dn_valid | dn_ready (legacy stall semantics).
// While dn_valid=0 the payload is forced to BUBBLE_VAL. flush kills every stored entry.
module pipe_stage_skid #(
  parameter int unsigned       DATA_W     = 32,
  parameter logic [DATA_W-1:0] BUBBLE_VAL = {DATA_W{1'b0}},
  parameter bit                SKID_EN    = 1'b1,
  parameter int unsigned       CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              up_valid,
  output logic              up_ready,
  input  logic [DATA_W-1:0] up_data,
  output logic              dn_valid,
  input  logic              dn_ready,
  output logic [DATA_W-1:0] dn_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  bp_cycles
);

  // The state encoding doubles as the occupancy count.
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  localparam logic [CNT_W-1:0] BP_ONE = CNT_W'(1);

  logic [1:0]        r_state;
  logic [DATA_W-1:0] r_out;
  logic [DATA_W-1:0] r_skid;
  logic              r_out_vld;
  logic              r_up_rdy;
  logic [CNT_W-1:0]  r_bp;

  logic              w_up_fire;
  logic              w_dn_fire;
  logic [1:0]        w_state_nxt;
  logic [DATA_W-1:0] w_out_nxt;
  logic [DATA_W-1:0] w_skid_nxt;

  assign up_ready  = SKID_EN ? r_up_rdy : (!r_out_vld || dn_ready);
  assign dn_valid  = r_out_vld;
  assign dn_data   = r_out;
  assign occupancy = r_state;
  assign bp_cycles = r_bp;

  assign w_up_fire = up_valid && up_ready;
  assign w_dn_fire = r_out_vld && dn_ready;

  // Next-state and next-payload logic for the handshake update (flush and reset are applied in the register block).
  always_comb begin
    w_state_nxt = r_state;
    w_out_nxt   = r_out;
    w_skid_nxt  = r_skid;
    if (SKID_EN) begin
      case (r_state)
        ST_EMPTY: begin
          if (w_up_fire) begin
            w_state_nxt = ST_ONE;
            w_out_nxt   = up_data;
          end
        end
        ST_ONE: begin
          if (w_up_fire && w_dn_fire) begin
            w_out_nxt = up_data;
          end else if (w_dn_fire) begin
            w_state_nxt = ST_EMPTY;
            w_out_nxt   = BUBBLE_VAL;
          end else if (w_up_fire) begin
            w_state_nxt = ST_FULL;
            w_skid_nxt  = up_data;
          end
        end
        ST_FULL: begin
          if (w_dn_fire) begin
            w_state_nxt = ST_ONE;
            w_out_nxt   = r_skid;
            w_skid_nxt  = BUBBLE_VAL;
          end
        end
        default: begin
          w_state_nxt = ST_EMPTY;
          w_out_nxt   = BUBBLE_VAL;
          w_skid_nxt  = BUBBLE_VAL;
        end
      endcase
    end else begin
      if (w_up_fire) begin
        w_state_nxt = ST_ONE;
        w_out_nxt   = up_data;
      end else if (w_dn_fire) begin
        w_state_nxt = ST_EMPTY;
        w_out_nxt   = BUBBLE_VAL;
      end
    end
  end

  // Storage registers. Priority is rst > flush > handshake. dn_valid and up_ready are
  // kept as their own flops so that neither output passes through decode logic.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_state   <= ST_EMPTY;
      r_out     <= BUBBLE_VAL;
      r_skid    <= BUBBLE_VAL;
      r_out_vld <= 1'b0;
      r_up_rdy  <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_out     <= w_out_nxt;
      r_skid    <= w_skid_nxt;
      r_out_vld <= (w_state_nxt != ST_EMPTY);
      r_up_rdy  <= (w_state_nxt != ST_FULL);
    end
  end

  // Saturating backpressure counter. A flush does not clear it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bp <= '0;
    end else if (r_out_vld && !dn_ready && (r_bp != '1)) begin
      r_bp <= r_bp + BP_ONE;
    end
  end

endmodule
